// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounces raw active-low keys into level, press, release, long-press and toggle outputs
module key_conditioner #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int N_KEYS      = 2,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_toggle
);

  // Prescaler divides clk down to a 1 ms tick shared by every key.
  localparam int DIV = CLK_FREQ / 1000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DW  = $clog2(DEBOUNCE_MS + 1);
  localparam int HW  = $clog2(LONG_MS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_MS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [PW-1:0]     presc_q, presc_d;
  logic              ms_tick;

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] k;

  state_e            state_q [N_KEYS];
  state_e            state_d [N_KEYS];
  logic [DW-1:0]     dcnt_q  [N_KEYS];
  logic [DW-1:0]     dcnt_d  [N_KEYS];
  logic [HW-1:0]     hcnt_q  [N_KEYS];
  logic [HW-1:0]     hcnt_d  [N_KEYS];
  logic [N_KEYS-1:0] long_done_q, long_done_d;

  logic [N_KEYS-1:0] level_q, level_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] toggle_q, toggle_d;

  assign ms_tick = (presc_q == PRE_LAST);
  // k is the synchronized key, inverted so that 1 means pressed.
  assign k       = ~sync2_q;

  // Free-running prescaler next value and two-flop synchronizer shift.
  always_comb begin
    presc_d = ms_tick ? '0 : presc_q + 1'b1;
    sync1_d = key_n;
    sync2_d = sync1_q;
  end

  // Per-key debounce / hold FSMs; keys never interact, so all events land in their own bit.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]     = state_q[i];
      dcnt_d[i]      = dcnt_q[i];
      hcnt_d[i]      = hcnt_q[i];
      long_done_d[i] = long_done_q[i];
      level_d[i]     = level_q[i];
      toggle_d[i]    = toggle_q[i];
      press_d[i]     = 1'b0;
      release_d[i]   = 1'b0;
      long_d[i]      = 1'b0;

      case (state_q[i])
        IDLE: begin
          level_d[i] = 1'b0;
          if (k[i]) begin
            state_d[i] = PRESS_WAIT;
            dcnt_d[i]  = '0;
          end
        end

        PRESS_WAIT: begin
          if (!k[i]) begin
            // Any release before acceptance restarts the debounce from scratch.
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else if (ms_tick) begin
            if (dcnt_q[i] == DEB_LAST) begin
              state_d[i]     = PRESSED;
              dcnt_d[i]      = DEB_MAX;
              press_d[i]     = 1'b1;
              level_d[i]     = 1'b1;
              toggle_d[i]    = ~toggle_q[i];
              hcnt_d[i]      = '0;
              long_done_d[i] = 1'b0;
            end else if (dcnt_q[i] != DEB_MAX) begin
              dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
          end
        end

        PRESSED: begin
          if (ms_tick && (hcnt_q[i] != HOLD_MAX)) begin
            hcnt_d[i] = hcnt_q[i] + 1'b1;
          end
          // Also fires if the hold saturated while a release was being debounced.
          if (!long_done_q[i] &&
              ((hcnt_q[i] == HOLD_MAX) || (ms_tick && (hcnt_q[i] == HOLD_LAST)))) begin
            long_d[i]      = 1'b1;
            long_done_d[i] = 1'b1;
          end
          if (!k[i]) begin
            state_d[i] = RELEASE_WAIT;
            dcnt_d[i]  = '0;
          end
        end

        RELEASE_WAIT: begin
          if (ms_tick && (hcnt_q[i] != HOLD_MAX)) begin
            hcnt_d[i] = hcnt_q[i] + 1'b1;
          end
          if (k[i]) begin
            // Release bounce: resume the hold without a new press and keep long_done.
            state_d[i] = PRESSED;
          end else if (ms_tick) begin
            if (dcnt_q[i] == DEB_LAST) begin
              state_d[i]   = IDLE;
              dcnt_d[i]    = DEB_MAX;
              release_d[i] = 1'b1;
              level_d[i]   = 1'b0;
            end else if (dcnt_q[i] != DEB_MAX) begin
              dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
          end
        end

        default: begin
          state_d[i] = IDLE;
          level_d[i] = 1'b0;
        end
      endcase
    end
  end

  // State register; reset returns everything to the released, idle condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      long_done_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      toggle_q    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      toggle_q    <= toggle_d;
      for (int i = 0; i < N_KEYS; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;
  assign key_toggle  = toggle_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [1:0] key_n;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] key_long;
  logic [1:0] key_toggle;

  int n_vec;
  int n_err;
  int cyc;
  int edge_cyc;
  int lat;
  int both_cnt;
  int press_cnt [2];
  int rel_cnt   [2];
  int long_cnt  [2];
  int press_at  [2];
  int rel_at    [2];
  int long_at   [2];

  key_conditioner #(
    .CLK_FREQ   (4000),
    .N_KEYS     (2),
    .DEBOUNCE_MS(3),
    .LONG_MS    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_toggle (key_toggle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle, sample 1 ns after the edge and log pulse events
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (key_press == 2'b11) both_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (key_press[i])   begin press_cnt[i]++; press_at[i] = cyc; end
      if (key_release[i]) begin rel_cnt[i]++;   rel_at[i]   = cyc; end
      if (key_long[i])    begin long_cnt[i]++;  long_at[i]  = cyc; end
    end
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  task automatic clear_counts();
    both_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_at[i] = -1; rel_at[i] = -1; long_at[i] = -1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 2'b11;
    steps(3);
    n_vec++;
    if ({key_level, key_press, key_release, key_long, key_toggle} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 0", {key_level, key_press, key_release, key_long, key_toggle});
    end
    rst_n = 1'b1;
    clear_counts();
    steps(10);
    n_vec++;
    if (press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1] !== 0) begin
      n_err++;
      $display("FAIL reset_quiet: got %0d pulses, expected 0", press_cnt[0] + press_cnt[1] + rel_cnt[0] + rel_cnt[1]);
    end
  endtask

  task automatic test_clean_press();
    clear_counts();
    edge_cyc = cyc;
    key_n[0] = 1'b0;
    steps(70);
    n_vec++;
    if (press_cnt[0] !== 1) begin
      n_err++; $display("FAIL clean_press_count: got %0d, expected 1", press_cnt[0]);
    end
    lat = press_at[0] - edge_cyc;
    n_vec++;
    if (lat < 11 || lat > 15) begin
      n_err++; $display("FAIL clean_press_latency: got %0d, expected 11..15", lat);
    end
    n_vec++;
    if (key_level[0] !== 1'b1 || key_toggle[0] !== 1'b1) begin
      n_err++; $display("FAIL clean_level_toggle: got %b%b, expected 11", key_level[0], key_toggle[0]);
    end
    n_vec++;
    if (long_cnt[0] !== 1 || long_at[0] - press_at[0] !== 40) begin
      n_err++; $display("FAIL clean_long: got count %0d delay %0d, expected 1 and 40", long_cnt[0], long_at[0] - press_at[0]);
    end
    n_vec++;
    if (press_cnt[1] !== 0 || key_level[1] !== 1'b0) begin
      n_err++; $display("FAIL clean_other_key: got %0d presses, expected 0", press_cnt[1]);
    end
    key_n[0] = 1'b1;
    steps(20);
    n_vec++;
    if (rel_cnt[0] !== 1 || key_level[0] !== 1'b0) begin
      n_err++; $display("FAIL clean_release: got %0d releases level %b, expected 1 and 0", rel_cnt[0], key_level[0]);
    end
  endtask

  task automatic test_bounce();
    clear_counts();
    for (int s = 0; s < 10; s++) begin
      key_n[0] = s[0];
      steps(2);
    end
    edge_cyc = cyc;
    key_n[0] = 1'b0;
    steps(30);
    n_vec++;
    if (press_cnt[0] !== 1) begin
      n_err++; $display("FAIL bounce_press_count: got %0d, expected 1", press_cnt[0]);
    end
    lat = press_at[0] - edge_cyc;
    n_vec++;
    if (lat < 1 || lat > 15) begin
      n_err++; $display("FAIL bounce_press_latency: got %0d, expected 1..15", lat);
    end
    n_vec++;
    if (rel_cnt[0] !== 0) begin
      n_err++; $display("FAIL bounce_release: got %0d, expected 0", rel_cnt[0]);
    end
  endtask

  task automatic test_release_glitch();
    clear_counts();
    steps(10);
    key_n[0] = 1'b1;
    steps(5);
    key_n[0] = 1'b0;
    steps(60);
    n_vec++;
    if (rel_cnt[0] !== 0 || press_cnt[0] !== 0) begin
      n_err++; $display("FAIL glitch_pulses: got %0d rel %0d press, expected 0 0", rel_cnt[0], press_cnt[0]);
    end
    n_vec++;
    if (key_level[0] !== 1'b1) begin
      n_err++; $display("FAIL glitch_level: got %b, expected 1", key_level[0]);
    end
    n_vec++;
    if (long_cnt[0] !== 1) begin
      n_err++; $display("FAIL glitch_long: got %0d, expected 1", long_cnt[0]);
    end
    key_n[0] = 1'b1;
    steps(20);
    n_vec++;
    if (rel_cnt[0] !== 1) begin
      n_err++; $display("FAIL glitch_final_release: got %0d, expected 1", rel_cnt[0]);
    end
  endtask

  task automatic test_toggle();
    n_vec++;
    if (key_toggle[1] !== 1'b0) begin
      n_err++; $display("FAIL toggle_initial: got %b, expected 0", key_toggle[1]);
    end
    for (int r = 0; r < 2; r++) begin
      clear_counts();
      key_n[1] = 1'b0;
      steps(20);
      n_vec++;
      if (press_cnt[1] !== 1 || key_toggle[1] !== (r == 0)) begin
        n_err++; $display("FAIL toggle_round%0d: got %0d presses toggle %b, expected 1 and %0d", r, press_cnt[1], key_toggle[1], r == 0);
      end
      edge_cyc = cyc;
      key_n[1] = 1'b1;
      steps(20);
      lat = rel_at[1] - edge_cyc;
      n_vec++;
      if (rel_cnt[1] !== 1 || lat < 11 || lat > 15) begin
        n_err++; $display("FAIL toggle_release%0d: got %0d releases latency %0d, expected 1 and 11..15", r, rel_cnt[1], lat);
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_counts();
    key_n = 2'b00;
    steps(20);
    n_vec++;
    if (both_cnt !== 1 || press_cnt[0] !== 1 || press_cnt[1] !== 1) begin
      n_err++; $display("FAIL simul_press: got both=%0d p0=%0d p1=%0d, expected 1 1 1", both_cnt, press_cnt[0], press_cnt[1]);
    end
    n_vec++;
    if (key_toggle !== 2'b11) begin
      n_err++; $display("FAIL simul_toggle: got %b, expected 11", key_toggle);
    end
    clear_counts();
    key_n[0] = 1'b1;
    steps(20);
    n_vec++;
    if (rel_cnt[0] !== 1 || rel_cnt[1] !== 0 || key_level !== 2'b10) begin
      n_err++; $display("FAIL simul_release0: got r0=%0d r1=%0d level=%b, expected 1 0 10", rel_cnt[0], rel_cnt[1], key_level);
    end
  endtask

  task automatic test_reset_mid_hold();
    key_n = 2'b11;
    steps(20);
    key_n = 2'b10;
    steps(20);
    n_vec++;
    if (key_level !== 2'b01 || key_toggle[0] !== 1'b0) begin
      n_err++; $display("FAIL midhold_setup: got level %b toggle %b, expected 01 and 0", key_level, key_toggle[0]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({key_level, key_press, key_release, key_long, key_toggle} !== 10'b0) begin
      n_err++; $display("FAIL midhold_async_reset: got %b, expected 0", {key_level, key_press, key_release, key_long, key_toggle});
    end
    steps(3);
    rst_n = 1'b1;
    clear_counts();
    edge_cyc = cyc;
    steps(25);
    lat = press_at[0] - edge_cyc;
    n_vec++;
    if (press_cnt[0] !== 1 || lat < 11 || lat > 15) begin
      n_err++; $display("FAIL midhold_repress: got %0d presses latency %0d, expected 1 and 11..15", press_cnt[0], lat);
    end
    n_vec++;
    if (key_toggle[0] !== 1'b1 || rel_cnt[0] !== 0 || long_cnt[0] !== 0) begin
      n_err++; $display("FAIL midhold_after: got toggle %b rel %0d long %0d, expected 1 0 0", key_toggle[0], rel_cnt[0], long_cnt[0]);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    clear_counts();
    rst_n = 1'b0;
    key_n = 2'b11;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
